line_clear_ctrl: RTL

//  Sequences the dual-port grid memory (port A read/write, port B read, 1-cycle read latency) to clear full rows.
//  On start it scans the playfield bottom-up, reading one cell per cycle on port B.
//  For each full row it copies every row above it down by one row, using port B for reads and port A for writes.
//  It then zeroes row 0, rescans the same row, and reports how many rows it cleared.

---
 rtl/line_clear_ctrl_pkg.sv | 31 +++
 rtl/line_clear_ctrl_if.sv | 25 ++
 rtl/line_clear_ctrl_grid_row_walker.sv | 62 ++++++
 rtl/line_clear_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/line_clear_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the row-clear sequencer.
// Default grid geometry matches the playfield used by the game FSM.
package line_clear_ctrl_pkg;

    localparam int GRID_COLS       = 10;
    localparam int GRID_ROWS       = 20;
    localparam int GRID_ADDR_WIDTH = 8;
    localparam int GRID_DATA_WIDTH = 8;
    localparam int LC_WIDTH        = 5;

    localparam logic [GRID_DATA_WIDTH-1:0] CELL_EMPTY = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EVAL,
        ST_SHIFT,
        ST_SHIFT_END,
        ST_CLEAR,
        ST_FINISH
    } lc_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [LC_WIDTH-1:0] sat_inc(input logic [LC_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/line_clear_ctrl_if.sv
// Grid memory port bundle: port A write, port B read with 1-cycle latency.
interface line_clear_ctrl_if
    import line_clear_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = GRID_ADDR_WIDTH,
    parameter int DATA_WIDTH = GRID_DATA_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] mem_addr_a;
    logic [DATA_WIDTH-1:0] mem_data_a;
    logic                  mem_we_a;
    logic [ADDR_WIDTH-1:0] mem_addr_b;
    logic [DATA_WIDTH-1:0] mem_q_b;

    modport master (
        output mem_addr_a, mem_data_a, mem_we_a, mem_addr_b,
        input  mem_q_b
    );

    modport slave (
        input  mem_addr_a, mem_data_a, mem_we_a, mem_addr_b,
        output mem_q_b
    );

endinterface

// File: rtl/line_clear_ctrl_grid_row_walker.sv
// (row, col) cell walker with a running row base so cell addresses need no multiplier.
// Load has priority over step; on column wrap the row optionally moves up or down.
module grid_row_walker
    import line_clear_ctrl_pkg::*;
#(
    parameter int COLS       = GRID_COLS,
    parameter int ROWS       = GRID_ROWS,
    parameter int ADDR_WIDTH = GRID_ADDR_WIDTH,
    localparam int RW        = idx_width(ROWS),
    localparam int CW        = idx_width(COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [RW-1:0]         load_row,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic                  step,
    input  logic                  row_wrap,
    input  logic                  row_up,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_col,
    output logic                  last_row
);

    localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(COLS);

    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [ADDR_WIDTH-1:0] base;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row  <= '0;
            col  <= '0;
            base <= '0;
        end else if (load) begin
            row  <= load_row;
            col  <= '0;
            base <= load_base;
        end else if (step) begin
            if (last_col) begin
                col <= '0;
                if (row_wrap) begin
                    if (row_up) begin
                        row  <= row + 1'b1;
                        base <= base + COLS_A;
                    end else begin
                        row  <= row - 1'b1;
                        base <= base - COLS_A;
                    end
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last_col = (col == CW'(COLS - 1));
    assign last_row = (row == '0);
    assign addr     = base + ADDR_WIDTH'(col);

endmodule

// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer: scans the grid bottom-up, shifts rows above each full row down,
// zeroes row 0 and rescans, counting the rows removed.
//
//  state        | meaning
//  ST_IDLE      | waiting for start, memory ports released
//  ST_SCAN      | reading the COLS cells of row r on port B
//  ST_EVAL      | last cell arrives; decide shift / clear / next row / finish
//  ST_SHIFT     | read (k-1,c), write previous read one row lower
//  ST_SHIFT_END | trailing write of the final shifted cell
//  ST_CLEAR     | zeroing row 0, then rescan row r
//  ST_FINISH    | done pulse, back to idle
module line_clear_ctrl
    import line_clear_ctrl_pkg::*;
#(
    parameter int COLS       = GRID_COLS,
    parameter int ROWS       = GRID_ROWS,
    parameter int ADDR_WIDTH = GRID_ADDR_WIDTH,
    parameter int DATA_WIDTH = GRID_DATA_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [LC_WIDTH-1:0] lines_cleared,
    line_clear_ctrl_if.master   mem
);

    localparam int RW = idx_width(ROWS);
    localparam logic [ADDR_WIDTH-1:0] COLS_A      = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] BOTTOM_BASE = ADDR_WIDTH'((ROWS - 1) * COLS);
    localparam logic [RW-1:0]         BOTTOM_ROW  = RW'(ROWS - 1);

    if (ROWS * COLS > (1 << ADDR_WIDTH)) begin : g_bad_size
        $error("line_clear_ctrl: ROWS*COLS does not fit in ADDR_WIDTH");
    end

    lc_state_e state, state_nxt;

    logic [RW-1:0]         r;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  full_flag, scan_d, rd_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  q_nz, full_now, shift_wr;
    logic                  pass_start, r_dec, lc_inc;

    logic                  wk_load, wk_step, wk_wrap, wk_last_col, wk_last_row;
    logic [RW-1:0]         wk_load_row;
    logic [ADDR_WIDTH-1:0] wk_load_base, wk_addr;

    grid_row_walker #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_walker (
        .clk       (clk),
        .reset     (reset),
        .load      (wk_load),
        .load_row  (wk_load_row),
        .load_base (wk_load_base),
        .step      (wk_step),
        .row_wrap  (wk_wrap),
        .row_up    (1'b0),
        .addr      (wk_addr),
        .last_col  (wk_last_col),
        .last_row  (wk_last_row)
    );

    assign q_nz     = (mem.mem_q_b != DATA_WIDTH'(CELL_EMPTY));
    assign full_now = full_flag & q_nz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // full_flag folds in read data one cycle behind the scan address; EVAL adds the last cell.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r             <= '0;
            r_base        <= '0;
            full_flag     <= 1'b0;
            scan_d        <= 1'b0;
            rd_d          <= 1'b0;
            addr_d        <= '0;
            lines_cleared <= '0;
        end else begin
            scan_d    <= (state == ST_SCAN);
            full_flag <= scan_d ? full_now : 1'b1;
            rd_d      <= (state == ST_SHIFT);
            addr_d    <= wk_addr;
            if (pass_start) begin
                r             <= BOTTOM_ROW;
                r_base        <= BOTTOM_BASE;
                lines_cleared <= '0;
            end else begin
                if (r_dec) begin
                    r      <= r - 1'b1;
                    r_base <= r_base - COLS_A;
                end
                if (lc_inc) lines_cleared <= sat_inc(lines_cleared);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wk_load      = 1'b0;
        wk_load_row  = '0;
        wk_load_base = '0;
        wk_step      = 1'b0;
        wk_wrap      = 1'b0;
        pass_start   = 1'b0;
        r_dec        = 1'b0;
        lc_inc       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pass_start   = 1'b1;
                    wk_load      = 1'b1;
                    wk_load_row  = BOTTOM_ROW;
                    wk_load_base = BOTTOM_BASE;
                    state_nxt    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                wk_step = 1'b1;
                if (wk_last_col) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                if (full_now && r != '0) begin
                    wk_load      = 1'b1;
                    wk_load_row  = r - 1'b1;
                    wk_load_base = r_base - COLS_A;
                    state_nxt    = ST_SHIFT;
                end else if (full_now) begin
                    wk_load   = 1'b1;
                    state_nxt = ST_CLEAR;
                end else if (r == '0) begin
                    state_nxt = ST_FINISH;
                end else begin
                    r_dec        = 1'b1;
                    wk_load      = 1'b1;
                    wk_load_row  = r - 1'b1;
                    wk_load_base = r_base - COLS_A;
                    state_nxt    = ST_SCAN;
                end
            end
            ST_SHIFT: begin
                wk_step = 1'b1;
                wk_wrap = 1'b1;
                if (wk_last_col && wk_last_row) state_nxt = ST_SHIFT_END;
            end
            ST_SHIFT_END: begin
                wk_load   = 1'b1;
                state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                wk_step = 1'b1;
                if (wk_last_col) begin
                    lc_inc       = 1'b1;
                    wk_load      = 1'b1;
                    wk_load_row  = r;
                    wk_load_base = r_base;
                    state_nxt    = ST_SCAN;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign busy     = (state == ST_SCAN) || (state == ST_EVAL) || (state == ST_SHIFT) ||
                      (state == ST_SHIFT_END) || (state == ST_CLEAR);
    assign done     = (state == ST_FINISH);
    assign shift_wr = rd_d && ((state == ST_SHIFT) || (state == ST_SHIFT_END));

    assign mem.mem_we_a   = shift_wr || (state == ST_CLEAR);
    assign mem.mem_addr_a = shift_wr ? addr_d + COLS_A :
                            (state == ST_CLEAR) ? wk_addr : '0;
    assign mem.mem_data_a = shift_wr ? mem.mem_q_b : '0;
    assign mem.mem_addr_b = ((state == ST_SCAN) || (state == ST_SHIFT)) ? wk_addr : '0;

endmodule
